// File: rtl/dcache_miss_ctrl.sv
// Dcache miss handler: dirty victim writeback, block fetch from RAM,
// then a one-cycle frame fill command.
module dcache_miss_ctrl #(
  parameter int WORDS     = 2,
  parameter int WORD_W    = 32,
  parameter int DTAG_W    = 26,
  parameter int DIDX_W    = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    miss_req,
  input  logic [31:0]             miss_addr,
  input  logic                    vic_dirty,
  input  logic [DTAG_W-1:0]       vic_tag,
  input  logic [WORDS*WORD_W-1:0] vic_data,
  input  logic [1:0]              ramstate,
  input  logic [WORD_W-1:0]       ramload,
  output logic                    ramREN,
  output logic                    ramWEN,
  output logic [31:0]             ramaddr,
  output logic [WORD_W-1:0]       ramstore,
  output logic                    miss_busy,
  output logic                    fill_we,
  output logic [DTAG_W-1:0]       fill_tag,
  output logic [DIDX_W-1:0]       fill_idx,
  output logic [WORDS*WORD_W-1:0] fill_data,
  output logic                    miss_done,
  output logic                    err
);

  localparam int WORD_COUNT = $clog2(WORDS);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int IDX_LO = WORD_COUNT + 2;

  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, WB, FETCH, COMMIT, FAULT
  } state_t;

  state_t state, next;

  logic [WORD_COUNT-1:0] cnt;
  logic [RW-1:0]         retry;
  logic [DTAG_W-1:0]     tag_q;
  logic [DIDX_W-1:0]     idx_q;
  logic [DTAG_W-1:0]     vtag_q;
  logic [WORD_W-1:0]     vdata_q [WORDS];
  logic [WORD_W-1:0]     fbuf_q  [WORDS];
  logic [WORDS*WORD_W-1:0] fbuf_flat;

  logic last, acc, er, give_up;
  logic unused_addr;

  assign last    = (cnt == WORD_COUNT'(WORDS - 1));
  assign acc     = (ramstate == ACCESS);
  assign er      = (ramstate == ERROR);
  assign give_up = er && (retry == RW'(MAX_RETRY - 1));
  assign unused_addr = ^miss_addr[IDX_LO-1:0];

  for (genvar g = 0; g < WORDS; g++) begin : g_pack
    assign fbuf_flat[g*WORD_W +: WORD_W] = fbuf_q[g];
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:   if (miss_req) next = vic_dirty ? WB : FETCH;
      WB:     if (acc && last) next = FETCH;
              else if (give_up) next = FAULT;
      FETCH:  if (acc && last) next = COMMIT;
              else if (give_up) next = FAULT;
      COMMIT: next = IDLE;
      FAULT:  next = FAULT;
      default: next = IDLE;
    endcase
  end

  // Word counter, retry counter and latched miss context
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      retry  <= '0;
      tag_q  <= '0;
      idx_q  <= '0;
      vtag_q <= '0;
      for (int k = 0; k < WORDS; k++) begin
        vdata_q[k] <= '0;
        fbuf_q[k]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: if (miss_req) begin
          cnt    <= '0;
          retry  <= '0;
          tag_q  <= miss_addr[31 -: DTAG_W];
          idx_q  <= miss_addr[IDX_LO +: DIDX_W];
          vtag_q <= vic_tag;
          for (int k = 0; k < WORDS; k++)
            vdata_q[k] <= vic_data[k*WORD_W +: WORD_W];
        end
        WB, FETCH: begin
          if (acc) begin
            retry <= '0;
            cnt   <= cnt + 1'b1;
            if (state == FETCH) fbuf_q[cnt] <= ramload;
          end else if (er) begin
            retry <= retry + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    miss_busy = (state != IDLE);
    fill_we   = 1'b0;
    miss_done = 1'b0;
    fill_tag  = '0;
    fill_idx  = '0;
    fill_data = '0;
    err       = 1'b0;
    unique case (state)
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = {vtag_q, idx_q, cnt, 2'b00};
        ramstore = vdata_q[cnt];
      end
      FETCH: begin
        ramREN  = 1'b1;
        ramaddr = {tag_q, idx_q, cnt, 2'b00};
      end
      COMMIT: begin
        fill_we   = 1'b1;
        miss_done = 1'b1;
        fill_tag  = tag_q;
        fill_idx  = idx_q;
        fill_data = fbuf_flat;
      end
      FAULT: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: transaction-queue model checked every
// cycle plus directed literal expectations.
module tb_dcache_miss_ctrl;

  localparam int WORDS     = 2;
  localparam int WORD_W    = 32;
  localparam int DTAG_W    = 26;
  localparam int DIDX_W    = 3;
  localparam int MAX_RETRY = 3;
  localparam int WC        = $clog2(WORDS);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic miss_req;
  logic [31:0] miss_addr;
  logic vic_dirty;
  logic [DTAG_W-1:0] vic_tag;
  logic [WORDS*WORD_W-1:0] vic_data;
  logic [1:0] ramstate;
  logic [WORD_W-1:0] ramload;
  logic ramREN, ramWEN, miss_busy, fill_we, miss_done, err;
  logic [31:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [DTAG_W-1:0] fill_tag;
  logic [DIDX_W-1:0] fill_idx;
  logic [WORDS*WORD_W-1:0] fill_data;

  dcache_miss_ctrl #(
    .WORDS(WORDS), .WORD_W(WORD_W), .DTAG_W(DTAG_W),
    .DIDX_W(DIDX_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK(clk), .RST(rst), .miss_req(miss_req),
    .miss_addr(miss_addr), .vic_dirty(vic_dirty),
    .vic_tag(vic_tag), .vic_data(vic_data),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .miss_busy(miss_busy),
    .fill_we(fill_we), .fill_tag(fill_tag),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .miss_done(miss_done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int fills   = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  // Model: a miss becomes a list of RAM word operations
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          word;
  } op_t;

  op_t ops[$];
  bit m_commit = 1'b0;
  bit m_fault  = 1'b0;
  int m_retry  = 0;
  logic [WORD_W-1:0] m_buf [WORDS];
  logic [DTAG_W-1:0] m_tag = '0;
  logic [DIDX_W-1:0] m_idx = '0;

  always @(posedge clk) begin
    if (rst) begin
      ops.delete();
      m_commit = 1'b0;
      m_fault  = 1'b0;
      m_retry  = 0;
      m_tag    = '0;
      m_idx    = '0;
      for (int k = 0; k < WORDS; k++) m_buf[k] = '0;
    end else if (m_fault) begin
    end else if (m_commit) begin
      m_commit = 1'b0;
    end else if (ops.size() > 0) begin
      if (ramstate == ACCESS) begin
        if (!ops[0].we) m_buf[ops[0].word] = ramload;
        void'(ops.pop_front());
        m_retry = 0;
        if (ops.size() == 0) m_commit = 1'b1;
      end else if (ramstate == ERROR) begin
        m_retry++;
        if (m_retry == MAX_RETRY) begin
          m_fault = 1'b1;
          ops.delete();
        end
      end
    end else if (miss_req) begin
      int unsigned idx, mbase, vbase;
      op_t o;
      idx   = (miss_addr >> (WC + 2)) % (1 << DIDX_W);
      mbase = miss_addr & ~32'(WORDS * 4 - 1);
      vbase = (32'(vic_tag) << (DIDX_W + WC + 2))
            | (idx << (WC + 2));
      m_tag = DTAG_W'(miss_addr >> (32 - DTAG_W));
      m_idx = DIDX_W'(idx);
      m_retry = 0;
      if (vic_dirty)
        for (int k = 0; k < WORDS; k++) begin
          o.we = 1'b1; o.addr = vbase + 4 * k; o.word = k;
          o.data = vic_data[k*WORD_W +: WORD_W];
          ops.push_back(o);
        end
      for (int k = 0; k < WORDS; k++) begin
        o.we = 1'b0; o.addr = mbase + 4 * k; o.word = k;
        o.data = '0;
        ops.push_back(o);
      end
    end
  end

  // Compare process: every cycle against the model
  always @(negedge clk) begin
    if (chk_on) begin
      logic e_ren, e_wen, e_busy;
      logic [31:0] e_addr, e_store;
      logic [WORDS*WORD_W-1:0] e_fd;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_fd = 0;
      if (!m_fault && !m_commit && ops.size() > 0) begin
        e_ren  = !ops[0].we;
        e_wen  = ops[0].we;
        e_addr = ops[0].addr;
        e_store = ops[0].we ? ops[0].data : 32'h0;
      end
      e_busy = m_fault || m_commit || (ops.size() > 0);
      if (m_commit)
        for (int k = 0; k < WORDS; k++)
          e_fd[k*WORD_W +: WORD_W] = m_buf[k];
      chk("ramREN", 128'(ramREN), 128'(e_ren));
      chk("ramWEN", 128'(ramWEN), 128'(e_wen));
      chk("ramaddr", 128'(ramaddr), 128'(e_addr));
      chk("ramstore", 128'(ramstore), 128'(e_store));
      chk("miss_busy", 128'(miss_busy), 128'(e_busy));
      chk("fill_we", 128'(fill_we), 128'(m_commit));
      chk("miss_done", 128'(miss_done), 128'(m_commit));
      chk("fill_tag", 128'(fill_tag), 128'(m_commit ? m_tag : '0));
      chk("fill_idx", 128'(fill_idx), 128'(m_commit ? m_idx : '0));
      chk("fill_data", 128'(fill_data), 128'(e_fd));
      chk("err", 128'(err), 128'(m_fault));
      if (fill_we) fills++;
    end
  end

  task automatic cyc(input logic req, input logic [1:0] rs,
                     input logic [31:0] ld);
    miss_req = req;
    ramstate = rs;
    ramload  = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int f0;
    rst = 1'b1; miss_req = 0; miss_addr = 0; vic_dirty = 0;
    vic_tag = 0; vic_data = 0; ramstate = FREE; ramload = 0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    cyc(0, FREE, 0);
    rst = 1'b0;
    chk("reset busy", 128'(miss_busy), 128'(0));
    chk("reset err", 128'(err), 128'(0));
    chk("reset addr", 128'(ramaddr), 128'(0));

    // Clean miss with two BUSY cycles per word
    miss_addr = 32'h0000_0040; vic_dirty = 0;
    cyc(1, FREE, 0);
    chk("t1 addr0", 128'(ramaddr), 128'h40);
    cyc(0, BUSY, 0); cyc(0, BUSY, 0);
    cyc(0, ACCESS, 32'hAAAA0001);
    chk("t1 addr1", 128'(ramaddr), 128'h44);
    cyc(0, BUSY, 0); cyc(0, BUSY, 0);
    cyc(0, ACCESS, 32'hAAAA0002);
    chk("t1 fill_we", 128'(fill_we), 128'(1));
    chk("t1 data", 128'(fill_data), 128'hAAAA0002_AAAA0001);
    chk("t1 tag", 128'(fill_tag), 128'(1));
    chk("t1 idx", 128'(fill_idx), 128'(0));
    cyc(0, FREE, 0);

    // Dirty miss; victim inputs change after the request cycle
    miss_addr = 32'h0000_0050; vic_dirty = 1; vic_tag = 1;
    vic_data = 64'hBEEF0001_BEEF0000;
    cyc(1, FREE, 0);
    vic_data = '0; vic_dirty = 0; vic_tag = '0;
    chk("t2 wb0 wen", 128'(ramWEN), 128'(1));
    chk("t2 wb0", 128'({ramaddr, ramstore}), 128'h50_BEEF0000);
    cyc(0, ACCESS, 0);
    chk("t2 wb1", 128'({ramaddr, ramstore}), 128'h54_BEEF0001);
    cyc(0, ACCESS, 0);
    chk("t2 rd0 ren", 128'({ramREN, ramWEN}), 128'b10);
    chk("t2 rd0", 128'(ramaddr), 128'h50);
    cyc(0, ACCESS, 32'h1111_1111);
    cyc(0, ACCESS, 32'h2222_2222);
    chk("t2 data", 128'(fill_data), 128'h22222222_11111111);
    chk("t2 idx", 128'(fill_idx), 128'(2));
    cyc(0, FREE, 0);

    // One ERROR then success
    miss_addr = 32'h1000_0080;
    cyc(1, FREE, 0);
    cyc(0, ERROR, 0);
    chk("t3 reissue", 128'(ramaddr), 128'h1000_0080);
    cyc(0, ACCESS, 32'h33);
    cyc(0, ACCESS, 32'h44);
    chk("t3 fill", 128'({fill_we, err}), 128'b10);
    cyc(0, FREE, 0);

    // Three ERRORs -> FAULT, requests ignored, RST clears
    miss_addr = 32'h0000_0200;
    cyc(1, FREE, 0);
    cyc(0, ERROR, 0); cyc(0, ERROR, 0);
    chk("t4 pre", 128'(err), 128'(0));
    cyc(0, ERROR, 0);
    chk("t4 err", 128'({err, miss_busy, ramREN, ramWEN}),
        128'b1100);
    f0 = fills;
    cyc(1, ACCESS, 0); cyc(1, ACCESS, 0); cyc(0, ACCESS, 0);
    chk("t4 stuck", 128'({err, miss_busy}), 128'b11);
    rst = 1'b1;
    cyc(0, FREE, 0);
    rst = 1'b0;
    chk("t4 rst", 128'({err, miss_busy}), 128'b00);
    chk("t4 nofill", 128'(fills - f0), 128'(0));

    // RST during FETCH word 1
    miss_addr = 32'h0000_0300;
    cyc(1, FREE, 0);
    cyc(0, ACCESS, 32'h55);
    chk("t5 word1", 128'(ramaddr), 128'h304);
    f0 = fills;
    rst = 1'b1;
    cyc(0, ACCESS, 32'h66);
    rst = 1'b0;
    chk("t5 idle", 128'({miss_busy, ramREN, fill_we, miss_done}),
        128'b0000);
    cyc(0, FREE, 0); cyc(0, FREE, 0);
    chk("t5 nofill", 128'(fills - f0), 128'(0));

    // Zero-wait latency; second request while busy is dropped
    miss_addr = 32'h0000_0400;
    f0 = fills;
    cyc(1, ACCESS, 0);
    cyc(1, ACCESS, 32'h77);
    chk("t6 N+2", 128'(fill_we), 128'(0));
    cyc(0, ACCESS, 32'h88);
    chk("t6 N+3", 128'(fill_we), 128'(1));
    chk("t6 data", 128'(fill_data), 128'h00000088_00000077);
    cyc(0, ACCESS, 0);
    chk("t6 dropped", 128'(miss_busy), 128'(0));
    cyc(0, ACCESS, 0);
    chk("t6 one fill", 128'(fills - f0), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
